// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction-fetch stage.
//   fetch_state_e : fetch FSM states
//   fault_cause_e : fetch fault cause encoding
//   NOP_INSTR_DEF : default word presented when no instruction is held (addi x0,x0,0)
//   PC_INC        : sequential PC increment
package fetch_pkg;
    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_DRAIN, S_HOLD} fetch_state_e;
    typedef enum logic [1:0] {FAULT_NONE, FAULT_TIMEOUT, FAULT_MISALIGN} fault_cause_e;
    localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0013;
    localparam logic [31:0] PC_INC        = 32'd4;
endpackage

// File: rtl/fetch_timeout_ctr.sv
// fetch_timeout_ctr: 8-bit response timeout counter for the fetch stage.
//   clk     in  clock
//   reset   in  synchronous active-low reset
//   clr     in  clear count to zero (has priority over en)
//   en      in  count one cycle
//   expired out high in the counting cycle that brings the count to TIMEOUT_CYCLES
module fetch_timeout_ctr
    import fetch_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expired
);
    localparam logic [7:0] LAST = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0] cnt_q, cnt_d;
    always_comb cnt_d = clr ? 8'd0 : en ? cnt_q + 8'd1 : cnt_q;
    // Flags the cycle whose increment reaches the limit, so the fault can be
    // registered on that same edge.
    assign expired = en && (cnt_q == LAST);
    always_ff @(posedge clk) begin
        if (!reset) cnt_q <= 8'd0;
        else        cnt_q <= cnt_d;
    end
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch with single-outstanding imem port and decode handshake.
//   clk, reset            clock; synchronous active-low reset
//   pc / next_pc          current PC in; combinational PC to load next edge out
//   redirect_valid/_pc    redirect from execute
//   imem_req/_addr        one-cycle request pulse and address
//   imem_rvalid/_rdata    memory response
//   if_valid/_ready       decode handshake
//   if_instr/_pc/_fault   instruction word, its PC, fetch fault
// Optional macro FETCH_MISALIGN_CHK_EN: fault misaligned PCs instead of fetching.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter logic [31:0] NOP_INSTR      = NOP_INSTR_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc,
    output logic [31:0] next_pc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic        if_fault
);
    fetch_state_e state_q, state_d;
    logic         kill_q, kill_d;
    logic         if_valid_q, if_valid_d;
    logic         if_fault_q, if_fault_d;
    logic [31:0]  if_instr_q, if_instr_d;
    logic [31:0]  if_pc_q, if_pc_d;
    logic         issue, expired, handoff;

    fetch_timeout_ctr #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
        .clk     (clk),
        .reset   (reset),
        .clr     (state_q != S_WAIT),
        .en      (state_q == S_WAIT),
        .expired (expired)
    );

    assign handoff  = if_valid_q && if_ready;
    assign imem_req = issue && reset;
`ifdef FETCH_MISALIGN_CHK_EN
    assign imem_addr = pc;
`else
    assign imem_addr = {pc[31:2], 2'b00};
`endif
    assign if_valid = if_valid_q;
    assign if_fault = if_fault_q;
    assign if_pc    = if_pc_q;
    assign if_instr = if_valid_q ? if_instr_q : NOP_INSTR;

    always_comb begin
        next_pc = pc;
        if (reset) next_pc = redirect_valid ? redirect_pc : handoff ? pc + PC_INC : pc;
    end

    always_comb begin
        state_d    = state_q;
        kill_d     = kill_q;
        if_valid_d = if_valid_q;
        if_fault_d = if_fault_q;
        if_instr_d = if_instr_q;
        if_pc_d    = if_pc_q;
        issue      = 1'b0;
        case (state_q)
            S_IDLE: state_d = S_ISSUE;
            S_ISSUE: begin
                // A late response to a timed-out request retires the kill here.
                if (kill_q && imem_rvalid) kill_d = 1'b0;
                // No request while killed or redirecting: the PC is about to change
                // and a request now would leave an orphan response in flight.
                if (!redirect_valid && !kill_q) begin
`ifdef FETCH_MISALIGN_CHK_EN
                    if (pc[1:0] != 2'b00) begin
                        state_d    = S_HOLD;
                        if_valid_d = 1'b1;
                        if_fault_d = 1'b1;
                        if_instr_d = NOP_INSTR;
                        if_pc_d    = pc;
                    end else begin
                        issue   = 1'b1;
                        state_d = S_WAIT;
                    end
`else
                    issue   = 1'b1;
                    state_d = S_WAIT;
`endif
                end
            end
            S_WAIT: begin
                if (redirect_valid) begin
                    state_d = imem_rvalid ? S_ISSUE : S_DRAIN;
                    kill_d  = !imem_rvalid;
                end else if (imem_rvalid) begin
                    state_d    = S_HOLD;
                    if_valid_d = 1'b1;
                    if_instr_d = imem_rdata;
                    if_pc_d    = pc;
                end else if (expired) begin
                    state_d    = S_HOLD;
                    if_valid_d = 1'b1;
                    if_fault_d = 1'b1;
                    if_instr_d = NOP_INSTR;
                    if_pc_d    = pc;
                    kill_d     = 1'b1;
                end
            end
            S_DRAIN: begin
                if (imem_rvalid) kill_d = 1'b0;
                if (imem_rvalid || redirect_valid) state_d = S_ISSUE;
            end
            S_HOLD: begin
                if (kill_q && imem_rvalid) kill_d = 1'b0;
                // Redirect wins over a coincident handoff; either way the slot empties.
                if (redirect_valid || if_ready) begin
                    state_d    = S_ISSUE;
                    if_valid_d = 1'b0;
                    if_fault_d = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            kill_q     <= 1'b0;
            if_valid_q <= 1'b0;
            if_fault_q <= 1'b0;
            if_instr_q <= NOP_INSTR;
            if_pc_q    <= 32'd0;
        end else begin
            state_q    <= state_d;
            kill_q     <= kill_d;
            if_valid_q <= if_valid_d;
            if_fault_q <= if_fault_d;
            if_instr_q <= if_instr_d;
            if_pc_q    <= if_pc_d;
        end
    end
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed bench with a PC register, latency-configurable memory and a program-order scoreboard.
module tb_fetch_stage;
    localparam int unsigned T = 16;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset, redirect_valid, imem_req, imem_rvalid, if_valid, if_ready, if_fault;
    logic [31:0] pc, next_pc, redirect_pc, imem_addr, imem_rdata, if_instr, if_pc;

    logic [31:0] pc_init, raddr, exp_pc;
    int          lat, cnt, passes = 0, checks = 0;
    bit          pend, req_fault, ef, prev_hold;

    always #5 clk = ~clk;

    fetch_stage #(.TIMEOUT_CYCLES(T), .NOP_INSTR(NOP)) dut (
        .clk            (clk),
        .reset          (reset),
        .pc             (pc),
        .next_pc        (next_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_instr       (if_instr),
        .if_pc          (if_pc),
        .if_fault       (if_fault)
    );

    // ProgramCounter stand-in closing the PC loop.
    always @(posedge clk) pc <= reset ? next_pc : pc_init;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return 32'h0050_0093 + ((a & 32'hFFFF_FFFC) << 8);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Memory: answers each request after exactly lat cycles.
    initial begin
        imem_rvalid = 1'b0;
        imem_rdata  = 32'd0;
        forever begin
            @(posedge clk); #1;
            imem_rvalid = 1'b0;
            if (!reset) pend = 1'b0;
            else if (pend) begin
                cnt--;
                if (cnt == 0) begin
                    imem_rvalid = 1'b1;
                    imem_rdata  = mem(raddr);
                    pend        = 1'b0;
                end
            end
        end
    end

    // Scoreboard: program-order PC, data from memory, fault iff response slower than the timeout.
    always @(negedge clk) begin
        if (!reset) begin
            chk("rst_next_pc", next_pc, pc);
            exp_pc    = pc_init;
            req_fault = 1'b0;
            prev_hold = 1'b0;
        end else begin
            chk("next_pc", next_pc, redirect_valid ? redirect_pc : (if_valid && if_ready) ? pc + 32'd4 : pc);
            if (imem_req) begin
                chk("one_outstanding", {31'd0, pend}, 32'd0);
                chk("req_pc", pc, exp_pc);
                chk("imem_addr", imem_addr, exp_pc & 32'hFFFF_FFFC);
                pend      = 1'b1;
                cnt       = lat;
                raddr     = imem_addr;
                req_fault = lat > int'(T);
            end
            ef = req_fault;
`ifdef FETCH_MISALIGN_CHK_EN
            if (exp_pc[1:0] != 2'b00) ef = 1'b1;
`endif
            if (prev_hold) chk("hold_valid", {31'd0, if_valid}, 32'd1);
            if (if_valid) begin
                chk("sb_pc", if_pc, exp_pc);
                chk("sb_fault", {31'd0, if_fault}, {31'd0, ef});
                chk("sb_instr", if_instr, ef ? NOP : mem(exp_pc));
            end else begin
                chk("idle_instr", if_instr, NOP);
                chk("idle_fault", {31'd0, if_fault}, 32'd0);
            end
            prev_hold = if_valid && !if_ready && !redirect_valid;
            if (redirect_valid) exp_pc = redirect_pc;
            else if (if_valid && if_ready) exp_pc = exp_pc + 32'd4;
        end
    end

    task automatic do_reset(input logic [31:0] p, input int l, input logic rdy);
        reset = 1'b0; redirect_valid = 1'b0; if_ready = rdy; pc_init = p; lat = l;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
    endtask

    task automatic wait_req(input int bound);
        int n = 0;
        @(negedge clk);
        while (!imem_req && n < bound) begin @(negedge clk); n++; end
        chk("wait_req", {31'd0, imem_req}, 32'd1);
    endtask

    task automatic wait_valid(input int bound);
        int n = 0;
        @(negedge clk);
        while (!if_valid && n < bound) begin @(negedge clk); n++; end
        chk("wait_valid", {31'd0, if_valid}, 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b0; if_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'd0;
        pc_init = 32'd0; lat = 1; pend = 1'b0;

        // Basic fetch, latency 1, then 5 cycles of back-pressure.
        do_reset(32'd0, 1, 1'b1);
        @(negedge clk);
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_valid", {31'd0, if_valid}, 32'd0);
        chk("rst_fault", {31'd0, if_fault}, 32'd0);
        chk("rst_instr", if_instr, 32'h0000_0013);
        chk("rst_if_pc", if_pc, 32'd0);
        @(negedge clk);
        chk("c1_req", {31'd0, imem_req}, 32'd1);
        chk("c1_addr", imem_addr, 32'd0);
        repeat (2) @(negedge clk);
        chk("c3_valid", {31'd0, if_valid}, 32'd1);
        chk("c3_if_pc", if_pc, 32'd0);
        chk("c3_instr", if_instr, 32'h0050_0093);
        chk("c3_next_pc", next_pc, 32'd4);
        @(posedge clk); #1 if_ready = 1'b0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_valid_lit", {31'd0, if_valid}, 32'd1);
            chk("hold_if_pc", if_pc, 32'd4);
            chk("hold_instr", if_instr, 32'h0050_0493);
            chk("hold_next_pc", next_pc, 32'd4);
            chk("hold_no_req", {31'd0, imem_req}, 32'd0);
        end
        @(posedge clk); #1 if_ready = 1'b1;
        @(negedge clk);
        chk("release_next_pc", next_pc, 32'd8);

        // Redirect during WAIT with latency 4; stale response must be dropped.
        do_reset(32'h40, 4, 1'b1);
        repeat (3) begin @(posedge clk); #1; end
        redirect_valid = 1'b1; redirect_pc = 32'h100;
        @(negedge clk);
        chk("redir_next_pc", next_pc, 32'h100);
        @(posedge clk); #1 redirect_valid = 1'b0;
        wait_req(20);
        chk("redir_addr", imem_addr, 32'h100);
        wait_valid(20);
        chk("redir_if_pc", if_pc, 32'h100);
        chk("redir_instr", if_instr, 32'h0051_0093);

        // Timeout: response after 20 cycles arrives too late and is discarded.
        do_reset(32'h200, 20, 1'b0);
        repeat (18) @(negedge clk);
        chk("to_c17_valid", {31'd0, if_valid}, 32'd0);
        @(negedge clk);
        chk("to_valid", {31'd0, if_valid}, 32'd1);
        chk("to_fault", {31'd0, if_fault}, 32'd1);
        chk("to_instr", if_instr, 32'h0000_0013);
        chk("to_if_pc", if_pc, 32'h200);
        repeat (6) @(negedge clk);
        chk("to_late_fault", {31'd0, if_fault}, 32'd1);
        chk("to_late_instr", if_instr, 32'h0000_0013);
        @(posedge clk); #1 lat = 1; if_ready = 1'b1;
        @(negedge clk);
        chk("to_next_pc", next_pc, 32'h204);
        @(negedge clk);
        chk("to_resume_req", {31'd0, imem_req}, 32'd1);
        chk("to_resume_addr", imem_addr, 32'h204);
        repeat (2) @(negedge clk);
        chk("to_resume_pc", if_pc, 32'h204);
        chk("to_resume_instr", if_instr, 32'h0052_0493);
        chk("to_resume_fault", {31'd0, if_fault}, 32'd0);

        // Latency exactly at the timeout limit still delivers data.
        do_reset(32'h300, 16, 1'b0);
        repeat (18) @(negedge clk);
        chk("edge_c17_valid", {31'd0, if_valid}, 32'd0);
        @(negedge clk);
        chk("edge_valid", {31'd0, if_valid}, 32'd1);
        chk("edge_fault", {31'd0, if_fault}, 32'd0);
        chk("edge_instr", if_instr, 32'h0053_0093);

        // PC wrap.
        do_reset(32'hFFFF_FFFC, 1, 1'b1);
        repeat (4) @(negedge clk);
        chk("wrap_if_pc", if_pc, 32'hFFFF_FFFC);
        chk("wrap_next_pc", next_pc, 32'd0);
        @(negedge clk);
        chk("wrap_addr", imem_addr, 32'd0);
        repeat (2) @(negedge clk);
        chk("wrap_pc0", if_pc, 32'd0);
        chk("wrap_instr", if_instr, 32'h0050_0093);

        // Misaligned PC.
        do_reset(32'h6, 1, 1'b1);
        repeat (2) @(negedge clk);
`ifdef FETCH_MISALIGN_CHK_EN
        chk("mis_no_req", {31'd0, imem_req}, 32'd0);
        @(negedge clk);
        chk("mis_fault", {31'd0, if_fault}, 32'd1);
        chk("mis_if_pc", if_pc, 32'h6);
        chk("mis_instr", if_instr, 32'h0000_0013);
`else
        chk("mis_req", {31'd0, imem_req}, 32'd1);
        chk("mis_addr", imem_addr, 32'h4);
        repeat (2) @(negedge clk);
        chk("mis_fault", {31'd0, if_fault}, 32'd0);
        chk("mis_if_pc", if_pc, 32'h6);
        chk("mis_instr", if_instr, 32'h0050_0493);
`endif
        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
